// File: rtl/not_not_pkg.sv
// Shared state encoding, operator codes and LFSR tap masks for the Not Not round controller.
package not_not_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_NEW_ROUND = 3'd1,
        S_DRAW      = 3'd2,
        S_WAIT_KEY  = 3'd3,
        S_CHECK     = 3'd4,
        S_LOSE      = 3'd5
    } state_t;

    localparam logic [1:0] OP_SINGLE     = 2'd0;
    localparam logic [1:0] OP_AND        = 2'd1;
    localparam logic [1:0] OP_OR         = 2'd2;
    localparam logic [1:0] OP_SINGLE_ALT = 2'd3;

    // Fibonacci taps, MSB-first: x^8+x^6+x^5+x^4+1 and x^16+x^14+x^13+x^11+1
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

endpackage

// File: rtl/not_not_round_ctrl_lfsr.sv
// Maximal-length Fibonacci LFSR that advances one step whenever enable is high.
module lfsr_nbit #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = '1,
    parameter logic [WIDTH-1:0] SEED  = '1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             enable,
    output logic [WIDTH-1:0] lfsr_out
);

    logic [WIDTH-1:0] lfsr_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= SEED;
        end else if (enable) begin
            lfsr_q <= {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
        end
    end

    assign lfsr_out = lfsr_q;

endmodule

// File: rtl/not_not_round_ctrl.sv
// Round controller for the Not Not game: random rounds, draw handshake, key judging, score tracking.
// Optional feature: define NOT_NOT_SPEEDUP_EN to shrink the answer window as the score grows.
module not_not_round_ctrl
    import not_not_pkg::*;
#(
    parameter int          NUM_COLOURS    = 4,
    parameter int          LFSR_WIDTH     = 16,
    parameter logic [15:0] SEED           = 16'hACE1,
    parameter int          TIMEOUT_CYCLES = 50_000_000,
    parameter int          SCORE_WIDTH    = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [NUM_COLOURS-1:0] keys,
    input  logic                   done_draw,
    output logic                   draw_req,
    output logic [1:0]             not_count,
    output logic [1:0]             logic_op,
    output logic [$clog2(NUM_COLOURS)-1:0] colour_a,
    output logic [$clog2(NUM_COLOURS)-1:0] colour_b,
    output logic [NUM_COLOURS-1:0] expected,
    output logic [SCORE_WIDTH-1:0] score,
    output logic [SCORE_WIDTH-1:0] highscore,
    output logic                   playing,
    output logic                   lose
);

    localparam int CW = $clog2(NUM_COLOURS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [15:0] TAPS_SEL = (LFSR_WIDTH == 8) ? {8'h00, LFSR_TAPS_8} : LFSR_TAPS_16;

    state_t                 state_q;
    logic [NUM_COLOURS-1:0] keys_q, keys_prev_q, expected_q, expected_d;
    logic [1:0]             not_count_q, logic_op_q;
    logic [CW-1:0]          colour_a_q, colour_b_q;
    logic [SCORE_WIDTH-1:0] score_q, highscore_q;
    logic [TW-1:0]          timer_q, windowLimit;
    logic                   draw_req_q, playing_q, lose_q, result_ok_q;

    logic [LFSR_WIDTH-1:0]  lfsrVal;
    logic [NUM_COLOURS-1:0] keyRise;
    logic                   keyPressed, pressOk, startGame, lfsrStep, unusedLfsr;

    function automatic logic [NUM_COLOURS-1:0] calcExpected(input logic [1:0] nots,
                                                            input logic [1:0] op,
                                                            input logic [CW-1:0] a,
                                                            input logic [CW-1:0] b);
        logic [NUM_COLOURS-1:0] ca, cb, m;
        ca = NUM_COLOURS'(1) << a;
        cb = NUM_COLOURS'(1) << b;
        case (op)
            OP_AND:                 m = ca & cb;
            OP_OR:                  m = ca | cb;
            OP_SINGLE, OP_SINGLE_ALT: m = ca;
            default:                m = ca;
        endcase
        return nots[0] ? ~m : m;
    endfunction

    // Stepping on the way into NEW_ROUND lets the round fields load from the stepped value on exit
    assign startGame = start && (state_q == S_IDLE || state_q == S_LOSE);
    assign lfsrStep  = startGame || (state_q == S_CHECK && result_ok_q);

    lfsr_nbit #(
        .WIDTH (LFSR_WIDTH),
        .TAPS  (TAPS_SEL[LFSR_WIDTH-1:0]),
        .SEED  (SEED[LFSR_WIDTH-1:0])
    ) u_lfsr (
        .clock    (clock),
        .resetn   (resetn),
        .enable   (lfsrStep),
        .lfsr_out (lfsrVal)
    );

    assign unusedLfsr = ^lfsrVal;
    assign expected_d = calcExpected(lfsrVal[1:0], lfsrVal[3:2], lfsrVal[4 +: CW], lfsrVal[4+CW +: CW]);

    assign keyRise    = keys_q & ~keys_prev_q;
    assign keyPressed = |keyRise;
    assign pressOk    = ((keyRise & (keyRise - NUM_COLOURS'(1))) == '0) && |(keyRise & expected_q);

`ifdef NOT_NOT_SPEEDUP_EN
    logic [TW-1:0] limit_q, limit_d;
    logic [63:0]   cut;

    always_comb begin
        cut = 64'(score_q) * 64'(TIMEOUT_CYCLES / 16);
        if (cut >= 64'(TIMEOUT_CYCLES - TIMEOUT_CYCLES / 4)) begin
            limit_d = TW'(TIMEOUT_CYCLES / 4);
        end else begin
            limit_d = TW'(64'(TIMEOUT_CYCLES) - cut);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            limit_q <= TW'(TIMEOUT_CYCLES);
        end else if (state_q == S_NEW_ROUND) begin
            limit_q <= limit_d;
        end
    end

    assign windowLimit = limit_q;
`else
    assign windowLimit = TW'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            keys_q      <= '0;
            keys_prev_q <= '0;
            expected_q  <= '0;
            not_count_q <= '0;
            logic_op_q  <= '0;
            colour_a_q  <= '0;
            colour_b_q  <= '0;
            score_q     <= '0;
            highscore_q <= '0;
            timer_q     <= '0;
            draw_req_q  <= 1'b0;
            playing_q   <= 1'b0;
            lose_q      <= 1'b0;
            result_ok_q <= 1'b0;
        end else begin
            keys_q      <= keys;
            keys_prev_q <= keys_q;
            case (state_q)
                S_IDLE, S_LOSE: begin
                    if (start) begin
                        state_q   <= S_NEW_ROUND;
                        score_q   <= '0;
                        playing_q <= 1'b1;
                        lose_q    <= 1'b0;
                    end
                end
                S_NEW_ROUND: begin
                    state_q     <= S_DRAW;
                    draw_req_q  <= 1'b1;
                    not_count_q <= lfsrVal[1:0];
                    logic_op_q  <= lfsrVal[3:2];
                    colour_a_q  <= lfsrVal[4 +: CW];
                    colour_b_q  <= lfsrVal[4+CW +: CW];
                    expected_q  <= expected_d;
                end
                S_DRAW: begin
                    if (done_draw) begin
                        state_q    <= S_WAIT_KEY;
                        draw_req_q <= 1'b0;
                        timer_q    <= '0;
                    end
                end
                S_WAIT_KEY: begin
                    // A press on the last timer cycle still takes priority over the timeout
                    if (keyPressed) begin
                        state_q     <= S_CHECK;
                        result_ok_q <= pressOk;
                    end else if (timer_q == windowLimit - TW'(1)) begin
                        state_q     <= S_CHECK;
                        result_ok_q <= (expected_q == '0);
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_CHECK: begin
                    if (result_ok_q) begin
                        state_q <= S_NEW_ROUND;
                        if (score_q != '1) begin
                            score_q <= score_q + SCORE_WIDTH'(1);
                        end
                    end else begin
                        state_q   <= S_LOSE;
                        playing_q <= 1'b0;
                        lose_q    <= 1'b1;
                        if (score_q > highscore_q) begin
                            highscore_q <= score_q;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign draw_req  = draw_req_q;
    assign not_count = not_count_q;
    assign logic_op  = logic_op_q;
    assign colour_a  = colour_a_q;
    assign colour_b  = colour_b_q;
    assign expected  = expected_q;
    assign score     = score_q;
    assign highscore = highscore_q;
    assign playing   = playing_q;
    assign lose      = lose_q;

endmodule

// File: tb/tb_not_not_round_ctrl.sv
// Directed self-checking bench for not_not_round_ctrl (4 colours, 16-cycle window, 2-bit score).
module tb_not_not_round_ctrl;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [3:0] keys;
    logic       done_draw;
    logic       draw_req;
    logic [1:0] not_count, logic_op, colour_a, colour_b;
    logic [3:0] expected;
    logic [1:0] score, highscore;
    logic       playing, lose;

    int testsRun  = 0;
    int failCount = 0;

    logic [15:0] modelLfsr;
    logic [1:0]  modelNot, modelOp, modelA, modelB;
    logic [3:0]  modelExpected;

    always #5 clock = ~clock;

    not_not_round_ctrl #(
        .NUM_COLOURS    (4),
        .LFSR_WIDTH     (16),
        .SEED           (16'hACE1),
        .TIMEOUT_CYCLES (16),
        .SCORE_WIDTH    (2)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .keys      (keys),
        .done_draw (done_draw),
        .draw_req  (draw_req),
        .not_count (not_count),
        .logic_op  (logic_op),
        .colour_a  (colour_a),
        .colour_b  (colour_b),
        .expected  (expected),
        .score     (score),
        .highscore (highscore),
        .playing   (playing),
        .lose      (lose)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic [3:0] k, input logic dd);
        start     = st;
        keys      = k;
        done_draw = dd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] required);
        testsRun++;
        if (actual !== required) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, required);
        end
    endtask

    // Reference round generator written from the feedback polynomial x^16+x^14+x^13+x^11+1
    task automatic modelStep();
        logic [3:0] ca, cb, m;
        modelLfsr = {modelLfsr[14:0], modelLfsr[15] ^ modelLfsr[13] ^ modelLfsr[12] ^ modelLfsr[10]};
        modelNot  = modelLfsr[1:0];
        modelOp   = modelLfsr[3:2];
        modelA    = modelLfsr[5:4];
        modelB    = modelLfsr[7:6];
        ca = 4'b0001 << modelA;
        cb = 4'b0001 << modelB;
        case (modelOp)
            2'd1:    m = ca & cb;
            2'd2:    m = ca | cb;
            default: m = ca;
        endcase
        modelExpected = modelNot[0] ? ~m : m;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_draw_req"}, 32'(draw_req), 32'd0);
        checkOutput({tag, "_fields"}, 32'({not_count, logic_op, colour_a, colour_b}), 32'd0);
        checkOutput({tag, "_expected"}, 32'(expected), 32'd0);
        checkOutput({tag, "_score"}, 32'(score), 32'd0);
        checkOutput({tag, "_highscore"}, 32'(highscore), 32'd0);
        checkOutput({tag, "_playing"}, 32'(playing), 32'd0);
        checkOutput({tag, "_lose"}, 32'(lose), 32'd0);
    endtask

    // Entered while the DUT sits in NEW_ROUND; leaves it on the first WAIT_KEY cycle
    task automatic drawRound(input string tag, input int hold);
        checkOutput({tag, "_nr_draw_req"}, 32'(draw_req), 32'd0);
        modelStep();
        tick();
        checkOutput({tag, "_draw_req"}, 32'(draw_req), 32'd1);
        checkOutput({tag, "_not_count"}, 32'(not_count), 32'(modelNot));
        checkOutput({tag, "_logic_op"}, 32'(logic_op), 32'(modelOp));
        checkOutput({tag, "_colour_a"}, 32'(colour_a), 32'(modelA));
        checkOutput({tag, "_colour_b"}, 32'(colour_b), 32'(modelB));
        checkOutput({tag, "_expected"}, 32'(expected), 32'(modelExpected));
        repeat (hold) tick();
        if (hold > 0) checkOutput({tag, "_draw_req_hold"}, 32'(draw_req), 32'd1);
        done_draw = 1'b1;
        tick();
        done_draw = 1'b0;
        checkOutput({tag, "_wait_draw_req"}, 32'(draw_req), 32'd0);
    endtask

    // Answers correctly (or lets a zero-mask round time out); leaves the DUT in NEW_ROUND
    task automatic playRound(input string tag, input int prevScore, input int pressDelay);
        int         expScore;
        int         window;
        logic [3:0] key;
        expScore = (prevScore >= 3) ? 3 : prevScore + 1;
        window   = 16;
`ifdef NOT_NOT_SPEEDUP_EN
        window = (prevScore >= 12) ? 4 : 16 - prevScore;
`endif
        if (modelExpected != 4'b0000) begin
            key = modelExpected & (~modelExpected + 4'd1);
            repeat (pressDelay) tick();
            keys = key;
            tick();
            tick();
            checkOutput({tag, "_check_lose"}, 32'(lose), 32'd0);
        end else begin
            repeat (window) tick();
        end
        keys = 4'b0000;
        tick();
        checkOutput({tag, "_score"}, 32'(score), 32'(expScore));
        checkOutput({tag, "_playing"}, 32'(playing), 32'd1);
        checkOutput({tag, "_lose"}, 32'(lose), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        applyStimulus(1'b0, 4'b0000, 1'b0);
        modelLfsr = 16'hACE1;
        repeat (3) tick();
        checkReset("reset");
        resetn = 1'b1;
        tick();
        tick();
        checkOutput("idle_playing", 32'(playing), 32'd0);

        // Round 1: key held from NEW_ROUND never counts, so the nonzero mask times out
        start = 1'b1;
        tick();
        checkOutput("r1_start_playing", 32'(playing), 32'd1);
        start = 1'b0;
        keys  = 4'b0010;
        drawRound("r1", 3);
        checkOutput("r1_hand_expected", 32'(expected), 32'h0000_000e);
        repeat (16) tick();
        checkOutput("r1_t16_lose", 32'(lose), 32'd0);
        checkOutput("r1_t16_playing", 32'(playing), 32'd1);
        tick();
        checkOutput("r1_t17_lose", 32'(lose), 32'd1);
        checkOutput("r1_t17_playing", 32'(playing), 32'd0);
        checkOutput("r1_highscore", 32'(highscore), 32'd0);
        keys = 4'b0000;

        // Round 2: single correct key
        start = 1'b1;
        tick();
        checkOutput("r2_restart_lose", 32'(lose), 32'd0);
        checkOutput("r2_restart_score", 32'(score), 32'd0);
        start = 1'b0;
        drawRound("r2", 0);
        playRound("r2", 0, 3);

        // Round 3: two keys rising together loses
        drawRound("r3", 0);
        tick();
        keys = 4'b0110;
        tick();
        tick();
        tick();
        checkOutput("r3_lose", 32'(lose), 32'd1);
        checkOutput("r3_highscore", 32'(highscore), 32'd1);
        checkOutput("r3_score", 32'(score), 32'd1);
        keys = 4'b0000;

        start = 1'b1;
        tick();
        checkOutput("r4_restart_score", 32'(score), 32'd0);
        checkOutput("r4_restart_highscore", 32'(highscore), 32'd1);
        start = 1'b0;

        // Round 4: press lands on the final timer cycle; rounds 5-7 saturate the score
        drawRound("r4", 0);
        playRound("r4", 0, 14);
        drawRound("r5", 0);
        playRound("r5", 1, 2);
        drawRound("r6", 0);
        playRound("r6", 2, 2);
        drawRound("r7", 0);
        playRound("r7", 3, 2);
        checkOutput("r7_highscore", 32'(highscore), 32'd1);

        // Reset in the middle of WAIT_KEY, then the first round must repeat
        drawRound("r8", 0);
        tick();
        tick();
        resetn = 1'b0;
        #1;
        checkReset("midreset");
        tick();
        resetn = 1'b1;
        modelLfsr = 16'hACE1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        drawRound("rst", 0);
        checkOutput("rst_hand_expected", 32'(expected), 32'h0000_000e);
        checkOutput("rst_hand_colour_b", 32'(colour_b), 32'd3);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
